id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
- REQ-001: Parameter XLEN, default 32, sets operand/immediate datapath width.
- REQ-002: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_i  input  1  reset, asynchronous, active-high.
- REQ-004: stall_i  input  1  hold all stage contents this cycle.
- REQ-005: flush_i  input  1  replace stage contents with a bubble this cycle.
- REQ-006: valid_i  input  1  decode-stage instruction is real (not a bubble).
- REQ-007: RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  input  1 each  decode control bits.
- REQ-008: ALUOp_i  input  2  decode ALU operation class.
- REQ-009: rs1_data_i, rs2_data_i, imm_i  input  XLEN each  register operands and sign-extended immediate.
- REQ-010: funct_i  input  10  {funct7, funct3} for ALU control.
- REQ-011: rs1_addr_i, rs2_addr_i, rd_addr_i  input  5 each  register indices for forwarding and writeback.
- REQ-012: Each input in REQ-007..REQ-011 SHALL have a registered output of equal width, named with suffix _o in place of _i.
- REQ-013: valid_o  output  1  execute-stage instruction is real.

Function
- REQ-014: Latency from any _i to its matching _o SHALL be exactly one clock edge when neither stall_i nor flush_i is asserted.
- REQ-015: Rising edge with flush_i=1 SHALL clear every control output, valid_o, and all data/index outputs to 0, whatever stall_i is.
- REQ-016: Rising edge with flush_i=0, stall_i=1 SHALL hold every output at its current value.
- REQ-017: Rising edge with flush_i=0, stall_i=0 SHALL load every output from its matching input, and valid_o from valid_i.
- REQ-018: Rising edge with flush_i=0, stall_i=0, valid_i=0 SHALL load RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o as 0 regardless of their inputs (bubbles never write state).
- REQ-019: Outputs SHALL be driven solely from registers; no combinational path from any input to any output.
- REQ-020: Stall held for N consecutive edges SHALL keep outputs unchanged for all N; release loads the inputs present on the first edge with stall_i=0.

Reset
- REQ-021: While rst_i=1, all outputs SHALL be 0 immediately, independent of clk_i.
- REQ-022: After rst_i deasserts, the first rising edge SHALL behave per REQ-015..REQ-018; no extra warm-up cycle.
- REQ-023: Reset asserted during a stall or flush SHALL override both.

Configuration
- REQ-024: Macro ID_EX_BUBBLE_CNT_EN defined SHALL add output bubble_cnt_o  output  32, a count of bubble cycles.
- REQ-025: With the macro, bubble_cnt_o SHALL increment on each rising edge where flush_i=1, or where stall_i=0 and valid_i=0; it SHALL saturate at 0xFFFFFFFF and reset to 0.
- REQ-026: With the macro, stalled edges with flush_i=0 SHALL NOT increment bubble_cnt_o.
- REQ-027: Without the macro, the port and counter SHALL be absent; all other behaviour is identical.

Verification
- REQ-028: Reset, then valid_i=1, RegWrite_i=1, ALUOp_i=2'b10, rs1_data_i=0x0000_0005, rd_addr_i=7 -> after one edge RegWrite_o=1, ALUOp_o=2'b10, rs1_data_o=0x5, rd_addr_o=7, valid_o=1.
- REQ-029: Load lw fields (MemRead_i=1, MemtoReg_i=1, imm_i=0x10), then stall_i=1 for 3 edges with inputs changed to 0 -> outputs stay MemRead_o=1, imm_o=0x10 for all 3; fourth edge with stall_i=0 loads 0s.
- REQ-030: flush_i=1 and stall_i=1 on the same edge with valid contents -> all outputs 0, valid_o=0.
- REQ-031: valid_i=0 with RegWrite_i=1, MemWrite_i=1 -> after edge RegWrite_o=0, MemWrite_o=0, valid_o=0.
- REQ-032: rst_i pulsed mid-cycle while outputs nonzero -> outputs 0 before next clock edge.
- REQ-033: With ID_EX_BUBBLE_CNT_EN: 2 flush edges, 1 valid_i=0 edge, 2 stalled edges -> bubble_cnt_o=3; preload 0xFFFFFFFF plus one flush -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_if.sv
// Decode-to-execute pipeline bundle: decode-side fields (_i) and the registered
// execute-side copies (_o), plus the stage stall/flush controls.
interface id_ex_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            flush_i;
   logic            valid_i;
   logic            RegWrite_i;
   logic            MemtoReg_i;
   logic            MemRead_i;
   logic            MemWrite_i;
   logic            ALUSrc_i;
   logic [1:0]      ALUOp_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic [XLEN-1:0] imm_i;
   logic [9:0]      funct_i;
   logic [4:0]      rs1_addr_i;
   logic [4:0]      rs2_addr_i;
   logic [4:0]      rd_addr_i;

   logic            valid_o;
   logic            RegWrite_o;
   logic            MemtoReg_o;
   logic            MemRead_o;
   logic            MemWrite_o;
   logic            ALUSrc_o;
   logic [1:0]      ALUOp_o;
   logic [XLEN-1:0] rs1_data_o;
   logic [XLEN-1:0] rs2_data_o;
   logic [XLEN-1:0] imm_o;
   logic [9:0]      funct_o;
   logic [4:0]      rs1_addr_o;
   logic [4:0]      rs2_addr_o;
   logic [4:0]      rd_addr_o;

   modport master (
      output stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
             ALUSrc_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, funct_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i,
      input  valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
             rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
             ALUSrc_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, funct_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i,
      output valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
             rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o
   );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and bubble gating of state-writing controls.
// Define ID_EX_BUBBLE_CNT_EN to add a saturating 32-bit bubble counter output.
module id_ex_reg #(
   parameter int XLEN = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   id_ex_if.slave      bus
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0] bubble_cnt_o
`endif
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            memto_reg;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src;
      logic [1:0]      alu_op;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [9:0]      funct;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
   } stage_t;

   stage_t stage_in_s;
   stage_t stage_nxt_s;
   stage_t stage_r;

   // Decode-side view; a bubble never carries register-file or memory writes
   always_comb begin
      stage_in_s           = '0;
      stage_in_s.valid     = bus.valid_i;
      stage_in_s.reg_write = bus.RegWrite_i & bus.valid_i;
      stage_in_s.memto_reg = bus.MemtoReg_i & bus.valid_i;
      stage_in_s.mem_read  = bus.MemRead_i  & bus.valid_i;
      stage_in_s.mem_write = bus.MemWrite_i & bus.valid_i;
      stage_in_s.alu_src   = bus.ALUSrc_i;
      stage_in_s.alu_op    = bus.ALUOp_i;
      stage_in_s.rs1_data  = bus.rs1_data_i;
      stage_in_s.rs2_data  = bus.rs2_data_i;
      stage_in_s.imm       = bus.imm_i;
      stage_in_s.funct     = bus.funct_i;
      stage_in_s.rs1_addr  = bus.rs1_addr_i;
      stage_in_s.rs2_addr  = bus.rs2_addr_i;
      stage_in_s.rd_addr   = bus.rd_addr_i;
   end

   // Flush wins over stall so a squashed instruction cannot linger in a stalled stage
   always_comb begin
      stage_nxt_s = stage_r;
      if (bus.flush_i) begin
         stage_nxt_s = '0;
      end else if (bus.stall_i) begin
         stage_nxt_s = stage_r;
      end else begin
         stage_nxt_s = stage_in_s;
      end
   end

   // Stage register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_r <= '0;
      end else begin
         stage_r <= stage_nxt_s;
      end
   end

   assign bus.valid_o    = stage_r.valid;
   assign bus.RegWrite_o = stage_r.reg_write;
   assign bus.MemtoReg_o = stage_r.memto_reg;
   assign bus.MemRead_o  = stage_r.mem_read;
   assign bus.MemWrite_o = stage_r.mem_write;
   assign bus.ALUSrc_o   = stage_r.alu_src;
   assign bus.ALUOp_o    = stage_r.alu_op;
   assign bus.rs1_data_o = stage_r.rs1_data;
   assign bus.rs2_data_o = stage_r.rs2_data;
   assign bus.imm_o      = stage_r.imm;
   assign bus.funct_o    = stage_r.funct;
   assign bus.rs1_addr_o = stage_r.rs1_addr;
   assign bus.rs2_addr_o = stage_r.rs2_addr;
   assign bus.rd_addr_o  = stage_r.rd_addr;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_r;
   logic        bubble_s;

   // Stalled edges hold an existing instruction and are not bubbles
   assign bubble_s = bus.flush_i | (~bus.stall_i & ~bus.valid_i);

   // Saturating bubble counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_r <= 32'h0000_0000;
      end else if (bubble_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
         bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end

   assign bubble_cnt_o = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: transaction-level model plus directed literal checks.
module tb_id_ex_reg;
   localparam int XLEN = 32;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            memto_reg;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src;
      logic [1:0]      alu_op;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [9:0]      funct;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
   } ins_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_ex_if #(.XLEN(XLEN)) bus();

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
`endif

   id_ex_reg #(.XLEN(XLEN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .bubble_cnt_o (bubble_cnt)
`endif
   );

   ins_t cur = '0;
   logic cur_flush = 1'b0;
   logic cur_stall = 1'b0;
   ins_t exp_ins;
   ins_t act;
   int   vec_cnt  = 0;
   int   miss_cnt = 0;

   assign bus.stall_i    = cur_stall;
   assign bus.flush_i    = cur_flush;
   assign bus.valid_i    = cur.valid;
   assign bus.RegWrite_i = cur.reg_write;
   assign bus.MemtoReg_i = cur.memto_reg;
   assign bus.MemRead_i  = cur.mem_read;
   assign bus.MemWrite_i = cur.mem_write;
   assign bus.ALUSrc_i   = cur.alu_src;
   assign bus.ALUOp_i    = cur.alu_op;
   assign bus.rs1_data_i = cur.rs1_data;
   assign bus.rs2_data_i = cur.rs2_data;
   assign bus.imm_i      = cur.imm;
   assign bus.funct_i    = cur.funct;
   assign bus.rs1_addr_i = cur.rs1_addr;
   assign bus.rs2_addr_i = cur.rs2_addr;
   assign bus.rd_addr_i  = cur.rd_addr;

   assign act = {bus.valid_o, bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                 bus.ALUSrc_o, bus.ALUOp_o, bus.rs1_data_o, bus.rs2_data_o, bus.imm_o,
                 bus.funct_o, bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o};

   task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
      vec_cnt++;
      if (a !== e) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   // What execute should see for an instruction issued by decode
   function automatic ins_t as_issued(input ins_t s);
      ins_t r = s;
      if (!s.valid) begin
         r.reg_write = 1'b0;
         r.mem_read  = 1'b0;
         r.mem_write = 1'b0;
         r.memto_reg = 1'b0;
      end
      return r;
   endfunction

   // Reference: the stage holds the last instruction issued since the last flush/reset
   always @(posedge clk or posedge rst) begin
      if (rst)              exp_ins <= '0;
      else if (cur_flush)   exp_ins <= '0;
      else if (!cur_stall)  exp_ins <= as_issued(cur);
   end

   always @(negedge clk) chk("stage", act, exp_ins);

   task automatic apply(input ins_t s, input logic f, input logic st);
      @(negedge clk);
      cur       = s;
      cur_flush = f;
      cur_stall = st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      ins_t s;
      #1 rst = 1'b1;
      #1 chk("reset_async", act, 160'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Simple ALU op
      s = '0; s.valid = 1'b1; s.reg_write = 1'b1; s.alu_op = 2'b10;
      s.rs1_data = 32'h0000_0005; s.rd_addr = 5'd7;
      apply(s, 1'b0, 1'b0);
      chk("alu_regwrite", bus.RegWrite_o, 160'd1);
      chk("alu_aluop",    bus.ALUOp_o,    160'd2);
      chk("alu_rs1",      bus.rs1_data_o, 160'd5);
      chk("alu_rd",       bus.rd_addr_o,  160'd7);
      chk("alu_valid",    bus.valid_o,    160'd1);

      // Load held through a 3-edge stall, then zeros loaded on release
      s = '0; s.valid = 1'b1; s.mem_read = 1'b1; s.memto_reg = 1'b1; s.imm = 32'h10;
      s.reg_write = 1'b1; s.rd_addr = 5'd3;
      apply(s, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply('0, 1'b0, 1'b1);
         chk("stall_memread", bus.MemRead_o, 160'd1);
         chk("stall_imm",     bus.imm_o,     160'h10);
      end
      apply('0, 1'b0, 1'b0);
      chk("release_memread", bus.MemRead_o, 160'd0);
      chk("release_imm",     bus.imm_o,     160'd0);

      // Flush together with stall clears a full stage
      s = '1;
      apply(s, 1'b0, 1'b0);
      chk("full_rs2", bus.rs2_data_o, 160'hFFFF_FFFF);
      apply(s, 1'b1, 1'b1);
      chk("flush_stall_all", act,         160'd0);
      chk("flush_stall_vld", bus.valid_o, 160'd0);

      // Bubble with write controls set
      s = '0; s.reg_write = 1'b1; s.mem_write = 1'b1; s.alu_src = 1'b1; s.rs1_data = 32'hAB;
      apply(s, 1'b0, 1'b0);
      chk("bubble_regwrite", bus.RegWrite_o, 160'd0);
      chk("bubble_memwrite", bus.MemWrite_o, 160'd0);
      chk("bubble_valid",    bus.valid_o,    160'd0);
      chk("bubble_alusrc",   bus.ALUSrc_o,   160'd1);
      chk("bubble_rs1",      bus.rs1_data_o, 160'hAB);

      // Mid-cycle reset pulse
      s = '1;
      apply(s, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1 chk("reset_mid", act, 160'd0);
      rst = 1'b0;

      // Mixed traffic, checked by the model every cycle
      for (int i = 0; i < 20; i++) begin
         s           = '0;
         s.valid     = (i % 4) != 1;
         s.reg_write = i[0];
         s.memto_reg = i[1];
         s.mem_read  = i[2];
         s.mem_write = i[3];
         s.alu_src   = i[1] ^ i[0];
         s.alu_op    = i[1:0];
         s.rs1_data  = 32'h1000_0000 + i;
         s.rs2_data  = 32'hA5A5_0000 ^ (i * 32'h0101);
         s.imm       = -i;
         s.funct     = 10'h3FF - i;
         s.rs1_addr  = i;
         s.rs2_addr  = 31 - i;
         s.rd_addr   = i + 5;
         apply(s, (i % 7) == 3, (i % 5) == 2);
      end

`ifdef ID_EX_BUBBLE_CNT_EN
      s = '0; s.valid = 1'b1;
      cur = s; cur_flush = 1'b0; cur_stall = 1'b0;
      @(negedge clk) rst = 1'b1;
      #1 chk("cnt_reset", bubble_cnt, 160'd0);
      @(negedge clk) rst = 1'b0;
      apply(s, 1'b1, 1'b0);
      apply(s, 1'b1, 1'b0);
      apply('0, 1'b0, 1'b0);
      apply(s, 1'b0, 1'b1);
      apply(s, 1'b0, 1'b1);
      chk("cnt_three", bubble_cnt, 160'd3);
      apply(s, 1'b0, 1'b0);
      @(negedge clk);
      force dut.bubble_cnt_r = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 release dut.bubble_cnt_r;
      apply(s, 1'b1, 1'b0);
      chk("cnt_saturate", bubble_cnt, 160'hFFFF_FFFF);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
